gmii_udp_av_rx: RTL

- Parametrised successor to the GMII UDP video/audio receiver.
- Parses one GMII byte stream (preamble included) at clk125 and filters on Ethernet/IPv4/UDP header fields.
- Splits the payload into a video pixel stream and an aux (audio) stream, each feeding its own external FIFO.
- Additions over the previous block: multiple channel IDs, configurable pixel width and payload lengths, UDP-length-bounded termination, FIFO-full detection and truncation handling.

---
 rtl/gmii_udp_av_rx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gmii_udp_av_rx.sv
// GMII UDP video/aux receiver: filters Ethernet/IPv4/UDP headers per channel and
// splits the payload into pixel and aux FIFO writes. GMII_AV_STATS_EN adds packet counters.
module gmii_udp_av_rx #(
  parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter int          NUM_CH        = 4,
  parameter int          CH_W          = 2,
  parameter int          PIX_BYTES     = 2,
  parameter int          VID_BYTES     = 1280,
  parameter int          AUX_BYTES     = 48
) (
  input  logic                      clk125,
  input  logic                      sys_rst_n,
  input  logic [CH_W-1:0]           ch_id,
  input  logic [7:0]                rxd,
  input  logic                      rx_dv,
  output logic [24+8*PIX_BYTES-1:0] vid_data,
  output logic                      vid_wr_en,
  input  logic                      vid_full,
  output logic [23:0]               aux_data,
  output logic                      aux_wr_en,
  input  logic                      aux_full,
  output logic                      pkt_active,
  output logic                      ovf_sticky
`ifdef GMII_AV_STATS_EN
  ,
  output logic [15:0]               pkt_ok_cnt,
  output logic [15:0]               pkt_flt_cnt,
  output logic [15:0]               pkt_trunc_cnt
`endif
);
  localparam int PW = 8*PIX_BYTES;
  localparam int VW = 24+PW;

  typedef enum logic [2:0] {IDLE, HDR, VID, AUX, DROP} state_e;

  state_e          state_q, state_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]     eth_type_q, eth_type_d, dst_port_q, dst_port_d, udp_len_q, udp_len_d;
  logic [7:0]      ip_ver_q, ip_ver_d, proto_q, proto_d;
  logic [31:0]     ip_dst_q, ip_dst_d;
  logic [1:0]      typ_q, typ_d, wb_q, wb_d;
  logic [11:0]     x_q, x_d, y_q, y_d;
  logic [15:0]     prem_q, prem_d, sec_q, sec_d, aux_sr_q, aux_sr_d;
  logic [PW-9:0]   pix_q, pix_d;
  logic [VW-1:0]   vid_data_q, vid_data_d;
  logic [23:0]     aux_data_q, aux_data_d;
  logic            vid_wr_q, vid_wr_d, aux_wr_q, aux_wr_d, act_q, act_d, ovf_q, ovf_d;
  logic            ch_ok, hdr_ok;
  logic [15:0]     vid_budget;

  function automatic logic [15:0] aux_budget(input logic [15:0] p);
    return (p > 16'(AUX_BYTES)) ? 16'(AUX_BYTES) : p;
  endfunction

  assign ch_ok  = 32'(ch_id) < 32'(NUM_CH);
  assign hdr_ok = eth_type_q == 16'h0800 && ip_ver_q == 8'h45 && proto_q == 8'h11 &&
                  dst_port_q == DST_PORT && ch_ok && ip_dst_q == IPV4_DST_BASE + 32'(ch_id) &&
                  rxd <= 8'h02 && udp_len_q >= 16'd12;
  assign vid_budget = (prem_q > 16'(VID_BYTES)) ? 16'(VID_BYTES) : prem_q;

  always_comb begin
    state_d = state_q;   byte_cnt_d = byte_cnt_q; eth_type_d = eth_type_q;
    dst_port_d = dst_port_q; udp_len_d = udp_len_q; ip_ver_d = ip_ver_q;
    proto_d = proto_q;   ip_dst_d = ip_dst_q;     typ_d = typ_q;  wb_d = wb_q;
    x_d = x_q;           y_d = y_q;               prem_d = prem_q; sec_d = sec_q;
    aux_sr_d = aux_sr_q; pix_d = pix_q;           vid_data_d = vid_data_q;
    aux_data_d = aux_data_q; vid_wr_d = 1'b0;     aux_wr_d = 1'b0; ovf_d = ovf_q;
    if (!rx_dv) begin
      // A gap ends the frame; any partially packed word is simply abandoned.
      state_d = IDLE; byte_cnt_d = '0; wb_d = '0;
    end else begin
      byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
      case (state_q)
        IDLE: state_d = HDR;
        HDR: begin
          case (byte_cnt_q)
            11'h14, 11'h15: eth_type_d = {eth_type_q[7:0], rxd};
            11'h16: ip_ver_d = rxd;
            11'h1F: proto_d  = rxd;
            11'h26, 11'h27, 11'h28, 11'h29: ip_dst_d = {ip_dst_q[23:0], rxd};
            11'h2C, 11'h2D: dst_port_d = {dst_port_q[7:0], rxd};
            11'h2E, 11'h2F: udp_len_d  = {udp_len_q[7:0], rxd};
            11'h32: begin
              if (hdr_ok) begin
                typ_d  = rxd[1:0];
                prem_d = udp_len_q - 16'd12;
              end else state_d = DROP;
            end
            11'h33: y_d[7:0] = rxd;
            11'h34: begin x_d[3:0] = rxd[7:4]; y_d[11:8] = rxd[3:0]; end
            11'h35: begin
              x_d[11:4] = rxd;
              wb_d = '0;
              if (typ_q != 2'd1 && vid_budget >= 16'(PIX_BYTES)) begin
                state_d = VID; sec_d = vid_budget;
              end else if (typ_q != 2'd0 && aux_budget(prem_q) >= 16'd3) begin
                state_d = AUX; sec_d = aux_budget(prem_q);
              end else state_d = DROP;
            end
            default: ;
          endcase
        end
        VID: begin
          sec_d  = sec_q - 16'd1;
          prem_d = prem_q - 16'd1;
          if (wb_q == 2'(PIX_BYTES-1)) begin
            wb_d = '0;
            if (vid_full) begin
              ovf_d = 1'b1; state_d = DROP;
            end else begin
              vid_wr_d   = 1'b1;
              vid_data_d = {x_q, y_q, pix_q, rxd};
              // Stop once another whole pixel no longer fits the video budget.
              if (sec_d < 16'(PIX_BYTES)) begin
                if (typ_q == 2'd2 && aux_budget(prem_d) >= 16'd3) begin
                  state_d = AUX; sec_d = aux_budget(prem_d);
                end else state_d = DROP;
              end
            end
          end else begin
            wb_d  = wb_q + 2'd1;
            pix_d = (PW-8)'({pix_q, rxd});
          end
        end
        AUX: begin
          sec_d = sec_q - 16'd1;
          if (wb_q == 2'd2) begin
            wb_d = '0;
            if (aux_full) begin
              ovf_d = 1'b1; state_d = DROP;
            end else begin
              aux_wr_d   = 1'b1;
              aux_data_d = {aux_sr_q, rxd};
              if (sec_d < 16'd3) state_d = DROP;
            end
          end else begin
            wb_d     = wb_q + 2'd1;
            aux_sr_d = {aux_sr_q[7:0], rxd};
          end
        end
        default: ;
      endcase
    end
    act_d = (state_d == VID) || (state_d == AUX);
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;   byte_cnt_q <= '0; eth_type_q <= '0; dst_port_q <= '0;
      udp_len_q <= '0;   ip_ver_q <= '0;   proto_q <= '0;    ip_dst_q <= '0;
      typ_q <= '0;       wb_q <= '0;       x_q <= '0;        y_q <= '0;
      prem_q <= '0;      sec_q <= '0;      aux_sr_q <= '0;   pix_q <= '0;
      vid_data_q <= '0;  aux_data_q <= '0; vid_wr_q <= 1'b0; aux_wr_q <= 1'b0;
      act_q <= 1'b0;     ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;     byte_cnt_q <= byte_cnt_d; eth_type_q <= eth_type_d;
      dst_port_q <= dst_port_d; udp_len_q <= udp_len_d; ip_ver_q <= ip_ver_d;
      proto_q <= proto_d;     ip_dst_q <= ip_dst_d;     typ_q <= typ_d;
      wb_q <= wb_d;           x_q <= x_d;               y_q <= y_d;
      prem_q <= prem_d;       sec_q <= sec_d;           aux_sr_q <= aux_sr_d;
      pix_q <= pix_d;         vid_data_q <= vid_data_d; aux_data_q <= aux_data_d;
      vid_wr_q <= vid_wr_d;   aux_wr_q <= aux_wr_d;     act_q <= act_d;
      ovf_q <= ovf_d;
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_wr_en  = vid_wr_q;
  assign aux_data   = aux_data_q;
  assign aux_wr_en  = aux_wr_q;
  assign pkt_active = act_q;
  assign ovf_sticky = ovf_q;

`ifdef GMII_AV_STATS_EN
  logic        ovf_ev, flt_ev, ok_ev, trunc_ev;
  logic [15:0] pkt_ok_cnt_q, pkt_ok_cnt_d, pkt_flt_cnt_q, pkt_flt_cnt_d;
  logic [15:0] pkt_trunc_cnt_q, pkt_trunc_cnt_d;

  assign ovf_ev   = rx_dv && ((state_q == VID && wb_q == 2'(PIX_BYTES-1) && vid_full) ||
                              (state_q == AUX && wb_q == 2'd2 && aux_full));
  assign flt_ev   = rx_dv && state_q == HDR && byte_cnt_q == 11'h32 && state_d == DROP;
  assign ok_ev    = rx_dv && (state_q inside {HDR, VID, AUX}) && state_d == DROP &&
                    !flt_ev && !ovf_ev;
  assign trunc_ev = ovf_ev || (!rx_dv && (state_q == VID || state_q == AUX));

  always_comb begin
    pkt_ok_cnt_d    = pkt_ok_cnt_q    + 16'(ok_ev    && pkt_ok_cnt_q    != 16'hFFFF);
    pkt_flt_cnt_d   = pkt_flt_cnt_q   + 16'(flt_ev   && pkt_flt_cnt_q   != 16'hFFFF);
    pkt_trunc_cnt_d = pkt_trunc_cnt_q + 16'(trunc_ev && pkt_trunc_cnt_q != 16'hFFFF);
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_ok_cnt_q <= '0; pkt_flt_cnt_q <= '0; pkt_trunc_cnt_q <= '0;
    end else begin
      pkt_ok_cnt_q <= pkt_ok_cnt_d; pkt_flt_cnt_q <= pkt_flt_cnt_d;
      pkt_trunc_cnt_q <= pkt_trunc_cnt_d;
    end
  end

  assign pkt_ok_cnt    = pkt_ok_cnt_q;
  assign pkt_flt_cnt   = pkt_flt_cnt_q;
  assign pkt_trunc_cnt = pkt_trunc_cnt_q;
`endif
endmodule
